// File: rtl/double_frame_buffer.sv
// rtl/double_frame_buffer.sv - two-bank frame buffer with vblank-aligned page flip and hardware clear
// Display reads the front bank; GPU writes and clears target the back bank.
module double_frame_buffer #(
  parameter int PIXEL_W = 4,
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int ADDR_W  = 17
) (
  input  logic               gpu_clk,
  input  logic               rst,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [PIXEL_W-1:0] rd_data,
  input  logic               frame_start,
  input  logic               swap_req,
  output logic               swap_pending,
  input  logic               clear_req,
  input  logic [PIXEL_W-1:0] clear_color,
  output logic               busy,
  output logic               front_sel
);
  localparam int DEPTH = H_RES * V_RES;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  generate
    if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_addr_check
      $error("ADDR_W too small for H_RES*V_RES pixels");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CLEAR, SWAP_WAIT} state_t;

  state_t              state, state_next;
  logic                armed;
  logic [ADDR_W-1:0]   counter;
  logic [PIXEL_W-1:0]  color;
  logic                start_clear, flip;
  logic                wr_fire, mem_we, rd_hit;
  logic [IDX_W-1:0]    mem_idx;
  logic [PIXEL_W-1:0]  mem_din;
  logic [PIXEL_W-1:0]  bank0 [DEPTH];
  logic [PIXEL_W-1:0]  bank1 [DEPTH];

  always_comb begin
    state_next  = state;
    start_clear = 1'b0;
    flip        = 1'b0;
    wr_ready    = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        wr_ready = armed;
        if (clear_req) begin
          start_clear = 1'b1;
          state_next  = CLEAR;
        end else if (swap_pending || swap_req) begin
          state_next = SWAP_WAIT;
        end
      end
      CLEAR: begin
        busy = 1'b1;
        if (counter == LAST) state_next = (swap_pending || swap_req) ? SWAP_WAIT : IDLE;
      end
      SWAP_WAIT: begin
        if (frame_start) begin
          flip       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // armed holds wr_ready low until the first edge after reset is released
  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      armed        <= 1'b0;
      counter      <= '0;
      color        <= '0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
    end else begin
      state <= state_next;
      armed <= 1'b1;
      if (start_clear) begin
        counter <= '0;
        color   <= clear_color;
      end else if (state == CLEAR) begin
        counter <= counter + 1'b1;
      end
      if (flip) begin
        front_sel    <= ~front_sel;
        swap_pending <= 1'b0;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  assign wr_fire = wr_valid && wr_ready && ({1'b0, wr_addr} < DEPTH_X);
  assign mem_we  = busy || wr_fire;
  assign mem_idx = busy ? counter[IDX_W-1:0] : wr_addr[IDX_W-1:0];
  assign mem_din = busy ? color : wr_data;
  assign rd_hit  = ({1'b0, rd_addr} < DEPTH_X);

  always_ff @(posedge gpu_clk) begin
    if (mem_we && front_sel)  bank0[mem_idx] <= mem_din;
    if (mem_we && !front_sel) bank1[mem_idx] <= mem_din;
  end

  always_ff @(posedge gpu_clk or posedge rst) begin
    if (rst)          rd_data <= '0;
    else if (!rd_hit) rd_data <= '0;
    else if (front_sel) rd_data <= bank1[rd_addr[IDX_W-1:0]];
    else              rd_data <= bank0[rd_addr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_double_frame_buffer.sv
// tb/tb_double_frame_buffer.sv - directed and randomized checks of double_frame_buffer against a pixel-array model
module tb_double_frame_buffer;
  localparam int PW = 4, HR = 16, VR = 8, AW = 8, DEPTH = HR * VR;

  logic gpu_clk = 0, rst = 0;
  logic wr_valid = 0, frame_start = 0, swap_req = 0, clear_req = 0;
  logic [AW-1:0] wr_addr = '0, rd_addr = '0;
  logic [PW-1:0] wr_data = '0, clear_color = '0;
  logic wr_ready, swap_pending, busy, front_sel;
  logic [PW-1:0] rd_data;

  int checks = 0, errors = 0, busy_cycles = 0;

  logic [PW-1:0] m_mem [2][DEPTH];
  bit m_known [2][DEPTH];
  bit m_front, m_pending, m_armed, m_waiting, m_rd_known;
  int m_clear_left, m_clear_pos;
  logic [PW-1:0] m_color, m_rd;

  double_frame_buffer #(.PIXEL_W(PW), .H_RES(HR), .V_RES(VR), .ADDR_W(AW)) dut (
    .gpu_clk(gpu_clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_start(frame_start), .swap_req(swap_req), .swap_pending(swap_pending),
    .clear_req(clear_req), .clear_color(clear_color), .busy(busy), .front_sel(front_sel)
  );

  always #5 gpu_clk = ~gpu_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_front = 0; m_pending = 0; m_armed = 0; m_waiting = 0;
    m_clear_left = 0; m_clear_pos = 0; m_rd = '0; m_rd_known = 1;
  endtask

  task automatic store(input bit b, input int a, input logic [PW-1:0] d);
    m_mem[b][a] = d;
    m_known[b][a] = 1;
  endtask

  task automatic check_outputs(input string tag);
    bit idle;
    idle = (m_clear_left == 0) && !m_waiting;
    chk({tag, ".wr_ready"}, 32'(wr_ready), 32'(m_armed && idle && !rst));
    chk({tag, ".busy"}, 32'(busy), 32'(m_clear_left > 0));
    chk({tag, ".swap_pending"}, 32'(swap_pending), 32'(m_pending));
    chk({tag, ".front_sel"}, 32'(front_sel), 32'(m_front));
    if (m_rd_known) chk({tag, ".rd_data"}, 32'(rd_data), 32'(m_rd));
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic cycle(input string tag);
    bit idle, flip;
    if (rst) begin
      model_reset();
    end else begin
      if (int'(rd_addr) < DEPTH) begin
        m_rd = m_mem[m_front][rd_addr];
        m_rd_known = m_known[m_front][rd_addr];
      end else begin
        m_rd = '0;
        m_rd_known = 1;
      end
      idle = (m_clear_left == 0) && !m_waiting;
      if (m_armed && idle && wr_valid && int'(wr_addr) < DEPTH) store(!m_front, int'(wr_addr), wr_data);
      flip = 0;
      if (m_clear_left > 0) begin
        store(!m_front, m_clear_pos, m_color);
        m_clear_pos++;
        m_clear_left--;
        if (m_clear_left == 0 && (m_pending || swap_req)) m_waiting = 1;
      end else if (m_waiting) begin
        if (frame_start) begin
          flip = 1;
          m_waiting = 0;
          m_front = !m_front;
        end
      end else if (clear_req) begin
        m_clear_left = DEPTH;
        m_clear_pos = 0;
        m_color = clear_color;
      end else if (m_pending || swap_req) begin
        m_waiting = 1;
      end
      if (flip) m_pending = 0;
      else if (swap_req) m_pending = 1;
      m_armed = 1;
    end
    @(posedge gpu_clk);
    #1;
    check_outputs(tag);
    if (busy) busy_cycles++;
    wr_valid = 0; swap_req = 0; clear_req = 0; frame_start = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst = 1;
    #2 check_outputs("reset_async");
    cycle("reset_held");
    rst = 0;
    cycle("reset_release");
    chk("ready_after_reset", 32'(wr_ready), 32'd1);

    // Write to bank 1, flip, read it back; frame_start in the swap_req cycle must not flip
    wr_valid = 1; wr_addr = 5; wr_data = 4'hA;
    cycle("wr5");
    swap_req = 1; frame_start = 1;
    cycle("swap_same_fs");
    chk("no_early_flip", 32'(front_sel), 32'd0);
    cycle("swap_wait");
    frame_start = 1;
    cycle("flip1");
    chk("flip1_front", 32'(front_sel), 32'd1);
    rd_addr = 5;
    cycle("rd5");
    chk("rd5_data", 32'(rd_data), 32'hA);

    // Full clear with swap and stray frame_start in the middle
    clear_color = 4'h3; clear_req = 1; busy_cycles = 0;
    cycle("clear_start");
    for (int i = 0; i < DEPTH + 4; i++) begin
      wr_valid = 1'($urandom); wr_addr = AW'($urandom_range(0, DEPTH - 1)); wr_data = PW'($urandom);
      rd_addr = AW'($urandom_range(0, DEPTH + 10));
      if (i == 20) swap_req = 1;
      if (i == 40) frame_start = 1;
      cycle("clearing");
    end
    chk("busy_cycles", 32'(busy_cycles), 32'(DEPTH));
    chk("clear_no_flip", 32'(front_sel), 32'd1);
    frame_start = 1;
    cycle("flip2");
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a);
      cycle("clear_rd");
      if (a % 16 == 0) chk("clear_px", 32'(rd_data), 32'h3);
    end

    // Out-of-range write must not alias onto address 0
    wr_valid = 1; wr_addr = 0; wr_data = 4'h5;
    cycle("wr0");
    wr_valid = 1; wr_addr = AW'(DEPTH); wr_data = 4'hF;
    chk("oor_ready", 32'(wr_ready), 32'd1);
    rd_addr = AW'(DEPTH);
    cycle("wr_oor");
    chk("oor_rd", 32'(rd_data), 32'h0);
    // Two swap requests merge into one flip
    swap_req = 1; cycle("swap_a");
    cycle("gap");
    swap_req = 1; cycle("swap_b");
    frame_start = 1; rd_addr = 0;
    cycle("flip3");
    chk("merge_front", 32'(front_sel), 32'd1);
    chk("merge_pending", 32'(swap_pending), 32'd0);
    cycle("rd0");
    chk("rd0_after_oor", 32'(rd_data), 32'h5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      wr_valid = 1'($urandom); wr_addr = AW'($urandom_range(0, DEPTH + 12)); wr_data = PW'($urandom);
      rd_addr = AW'($urandom_range(0, DEPTH + 12));
      swap_req = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      clear_req = ($urandom_range(0, 63) == 0);
      clear_color = PW'($urandom);
      cycle("random");
    end
    for (int i = 0; i < DEPTH + 4 && (busy || swap_pending); i++) begin
      frame_start = 1;
      cycle("drain");
    end

    // Reset in the middle of a clear
    clear_color = 4'h9; clear_req = 1;
    cycle("clear2_start");
    for (int i = 0; i < 30; i++) cycle("clear2");
    #2 rst = 1;
    #1;
    model_reset();
    check_outputs("rst_mid_clear");
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_front", 32'(front_sel), 32'd0);
    cycle("rst_hold");
    rst = 0;
    cycle("rst_release");
    swap_req = 1; cycle("swap4");
    cycle("wait4");
    frame_start = 1; cycle("flip4");
    for (int a = 0; a < 40; a++) begin
      rd_addr = AW'(a);
      cycle("partial_rd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
